// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: ALU_Control encodings,
// flag bit positions inside the 4-bit {N, C, V, Z} flag word, datapath widths
// and a helper for index widths.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int FLAG_W = 4;

  // ALU_Control encodings; codes 4'b1100..4'b1111 are undefined and are
  // forwarded to the ALU untouched.
  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_PASB = 4'b1010,
    ALU_SLL  = 4'b1011
  } alu_ctrl_e;

  // Bit positions inside alu_flags / rsp_flags ({Negative, Carry, Overflow, Zero}).
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 3;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational N-way arbiter. The search for a valid request
// starts at index ptr and wraps modulo N; the first hit wins. Driving ptr
// with zero gives plain fixed priority (lowest index wins).
// Outputs: one-hot grant, encoded winner index and an any-grant flag.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // Rotating priority search beginning at ptr; first valid request found wins.
  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational 32-bit ALU between N_REQ
// requesters. A valid/ready front end arbitrates, the winner's operands and
// control drive the ALU, and the ALU result/flags plus the winner's ID are
// captured into a one-entry response register (1 op/cycle, 1-cycle latency).
// Optional feature macro ALU_ARB_RR_EN: defined -> round-robin arbitration
// with a pointer register; undefined -> fixed priority, lowest index wins.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = idx_width(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  input  logic [N_REQ*4-1:0]    req_ctrl,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [31:0]           alu_result,
  input  logic [3:0]            alu_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic [3:0]            rsp_flags
);

  logic                   rsp_valid_reg;
  logic [ID_W-1:0]        rsp_id_reg;
  logic [DATA_W-1:0]      rsp_result_reg;
  logic [FLAG_W-1:0]      rsp_flags_reg;

  logic                   can_accept;
  logic [N_REQ-1:0]       arb_req;
  logic [ID_W-1:0]        arb_ptr;
  logic [N_REQ-1:0]       grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_any;

  // Per-requester payloads, zeroed unless that requester holds the grant.
  logic [DATA_W-1:0]      a_masked    [N_REQ];
  logic [DATA_W-1:0]      b_masked    [N_REQ];
  logic [CTRL_W-1:0]      ctrl_masked [N_REQ];

  // The response slot is free when empty or being drained this cycle.
  // Requests are masked during reset so nothing is granted while rst_n is low.
  assign can_accept = ~rsp_valid_reg | rsp_ready;
  assign arb_req    = (rst_n && can_accept) ? req_valid : '0;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req       (arb_req),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;

  // Advance the pointer past the winner on every accept, wrapping at N_REQ-1.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // Round-robin pointer register; frozen whenever nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign arb_ptr = ptr_reg;
`else
  assign arb_ptr = '0;
`endif

  // Mask each requester's payload with its grant bit.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_payload
      assign a_masked[gi]    = grant[gi] ? req_a[DATA_W*gi +: DATA_W]    : '0;
      assign b_masked[gi]    = grant[gi] ? req_b[DATA_W*gi +: DATA_W]    : '0;
      assign ctrl_masked[gi] = grant[gi] ? req_ctrl[CTRL_W*gi +: CTRL_W] : '0;
    end
  endgenerate

  // OR-combine the one-hot-masked payloads; all zero (ADD 0+0) with no grant.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    for (int i = 0; i < N_REQ; i++) begin
      alu_a    = alu_a    | a_masked[i];
      alu_b    = alu_b    | b_masked[i];
      alu_ctrl = alu_ctrl | ctrl_masked[i];
    end
  end

  // Response stage: load on accept, clear valid on a drain with no new accept,
  // hold everything otherwise (including under backpressure).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
    end else if (grant_any) begin
      rsp_valid_reg  <= 1'b1;
      rsp_id_reg     <= grant_idx;
      rsp_result_reg <= alu_result;
      rsp_flags_reg  <= alu_flags;
    end else if (rsp_ready) begin
      rsp_valid_reg  <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_flags  = rsp_flags_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter (N_REQ=2). Models the external ALU, drives
// a linear directed sequence, and checks responses against a scoreboard of
// expected {id, result, flags} pushed at the moment each grant is expected.
// Expected grant patterns follow ALU_ARB_RR_EN when it is defined.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int N  = 2;
  localparam int IW = 1;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [63:0] id;
    logic [31:0] result;
    logic [3:0]  flags;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*4-1:0]  req_ctrl;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [3:0]      alu_ctrl;
  logic [31:0]     alu_result;
  logic [3:0]      alu_flags;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
  logic [3:0]      rsp_flags;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  // External ALU model. N is the sign of the exact result (result[31] ^ V),
  // C is the adder carry-out (for SUB: 1 means no borrow). Undefined codes
  // return an arbitrary but deterministic value.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cy;
    logic        v;
    logic [3:0]  f;
    s  = '0;
    r  = '0;
    cy = 1'b0;
    v  = 1'b0;
    case (c)
      4'b0000: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cy = s[32];
        v  = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0001: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        cy = s[32];
        v  = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b1011: r = a << b[4:0];
      default: r = a ^ ~b;
    endcase
    f         = '0;
    f[FLAG_Z] = (r == 32'd0);
    f[FLAG_V] = v;
    f[FLAG_C] = cy;
    f[FLAG_N] = r[31] ^ v;
    return {f, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_ctrl[4*i +: 4] = c;
  endtask

  // One clock cycle, entered and left at posedge+1: drive, settle, check the
  // response slot against the scoreboard head, check the grant, push the
  // expected response of the granted requester, then advance the clock.
  task automatic cycle(input logic [1:0] vld, input logic rdy, input logic [1:0] exp_grant,
                       input string tag);
    int          idx;
    logic [35:0] m;
    req_valid = vld;
    rsp_ready = rdy;
    #1;
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk({tag, "_rsp_id"},     64'(rsp_id),     sb[0].id);
      chk({tag, "_rsp_result"}, 64'(rsp_result), 64'(sb[0].result));
      chk({tag, "_rsp_flags"},  64'(rsp_flags),  64'(sb[0].flags));
      if (rdy) void'(sb.pop_front());
    end
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(exp_grant));
    if (exp_grant == 2'b00) begin
      chk({tag, "_alu_idle"}, {28'd0, alu_ctrl, alu_a}, 64'd0);
      chk({tag, "_alu_b_idle"}, 64'(alu_b), 64'd0);
    end else begin
      idx = exp_grant[1] ? 1 : 0;
      m   = alu_model(req_a[32*idx +: 32], req_b[32*idx +: 32], req_ctrl[4*idx +: 4]);
      sb.push_back('{64'(idx), m[31:0], m[35:32]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    #3;
    chk("reset_rsp_valid",  64'(rsp_valid),  64'd0);
    chk("reset_rsp_id",     64'(rsp_id),     64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_rsp_flags",  64'(rsp_flags),  64'd0);
    chk("reset_req_ready",  64'(req_ready),  64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single op on requester 0: 5 + 3.
    set_req(0, 32'd5, 32'd3, ALU_ADD);
    cycle(2'b01, 1'b1, 2'b01, "t1_single");
    chk("t1_const_id",     64'(rsp_id),     64'd0);
    chk("t1_const_result", 64'(rsp_result), 64'd8);
    chk("t1_const_flags",  64'(rsp_flags),  64'd0);
    cycle(2'b00, 1'b1, 2'b00, "t1_drain");

    // Contention: both valid every cycle with the response always drained.
    set_req(0, 32'd10,  32'd20, ALU_ADD);
    set_req(1, 32'd100, 32'd7,  ALU_SUB);
    for (int k = 0; k < 4; k++) begin
      cycle(2'b11, 1'b1, RR ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b01, "t2_cont");
    end

    // Backpressure: response held, nothing accepted, response stays constant.
    for (int k = 0; k < 3; k++) begin
      cycle(2'b11, 1'b0, 2'b00, "t3_bp");
    end
    cycle(2'b11, 1'b1, RR ? 2'b10 : 2'b01, "t3_release");

    // Flags: signed overflow, then equal-operand subtract.
    set_req(1, 32'h7FFF_FFFF, 32'd1, ALU_ADD);
    cycle(2'b10, 1'b1, 2'b10, "t4_ovf");
    chk("t4_ovf_result", 64'(rsp_result), 64'h8000_0000);
    chk("t4_ovf_flags",  64'(rsp_flags),  64'(4'b0010));
    set_req(1, 32'h1234, 32'h1234, ALU_SUB);
    cycle(2'b10, 1'b1, 2'b10, "t4_zero");
    chk("t4_zero_result", 64'(rsp_result), 64'd0);
    chk("t4_zero_zflag",  64'(rsp_flags[FLAG_Z]), 64'd1);
    // Undefined control code is passed straight through to the ALU.
    set_req(1, 32'hA5A5_0F0F, 32'h0000_FFFF, 4'b1111);
    cycle(2'b10, 1'b1, 2'b10, "t4_undef");

    // Reset while a response is pending.
    set_req(0, 32'd1, 32'd2, ALU_OR);
    cycle(2'b01, 1'b1, 2'b01, "t5_accept");
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    chk("t5_async_rsp_valid",  64'(rsp_valid),  64'd0);
    chk("t5_async_req_ready",  64'(req_ready),  64'd0);
    chk("t5_async_rsp_result", 64'(rsp_result), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(2'b11, 1'b1, 2'b01, "t5_first");
    cycle(2'b00, 1'b1, 2'b00, "end_drain");
    cycle(2'b00, 1'b1, 2'b00, "end_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
